switch_debouncer: RTL and testbench

- Debounces one mechanical switch/button input sampled in the `clk_i` domain.
- Produces a stable, debounced level and a single-cycle pulse on each debounced rising edge.
- Sits directly behind board-level switch pins; feeds control logic that needs clean edges/levels.
- Internally: 2-flop input synchronizer, down-counter and 4-state FSM.

---
 rtl/debouncer_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/switch_debouncer.sv | 92 +++++++++
 tb/tb_switch_debouncer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debouncer_pkg.sv
// Shared types and elaboration helpers for the switch debouncer.
// Turns clock frequency and stable time into a cycle count and a counter width.
package debouncer_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  function automatic int unsigned stable_cycles(input int unsigned clk_freq,
                                                input int unsigned stable_ms);
    return (clk_freq / 1000) * stable_ms;
  endfunction

  // Wide enough to hold N-1 down to 0; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops reset to RstVal so the first synchronized sample is predictable.
module sync_2ff #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: non-blocking assignments make both flops sample together, so the
  // value really takes two edges to travel from d to q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RstVal;
      q  <= RstVal;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces one switch input: a 2-flop synchronizer feeds a 4-state FSM
// and a down-counter. Produces a registered level and a rising-edge tick.
module switch_debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned ClkFreq    = 100_000_000,
  parameter int unsigned StableTime = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic db_level_o,
  output logic db_tick_o
);

  localparam int unsigned StableCycles = stable_cycles(ClkFreq, StableTime);
  localparam int unsigned CntW         = cnt_width(StableCycles);
  localparam logic [CntW-1:0] CntLoad  = CntW'(StableCycles - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  generate
    if (StableCycles < 1) begin : g_bad_cfg
      $error("switch_debouncer: StableCycles must be at least 1");
    end
  endgenerate

  logic            sw_s;
  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_d, tick_d;

  sync_2ff #(
    .RstVal(1'b0)
  ) u_sync (
    .clk  (clk_i),
    .rst_n(rst_i),
    .d    (sw_i),
    .q    (sw_s)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ZERO;
      cnt_q      <= '0;
      db_level_o <= 1'b0;
      db_tick_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_o <= level_d;
      db_tick_o  <= tick_d;
    end
  end

  // A flip of sw_s always wins over the counter reaching zero, so a glitch
  // in the last count cycle still rejects the transition.
  always_comb begin
    // NOTE: every output of this block gets a default first; without it any
    // path that skips an assignment would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          cnt_d   = CntLoad;
        end
      end
      WAIT1: begin
        if (!sw_s)               state_d = ZERO;
        else if (cnt_q != '0)    cnt_d   = cnt_q - CntOne;
        else                     state_d = ONE;
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          cnt_d   = CntLoad;
        end
      end
      WAIT0: begin
        if (sw_s)                state_d = ONE;
        else if (cnt_q != '0)    cnt_d   = cnt_q - CntOne;
        else                     state_d = ZERO;
      end
      default: state_d = ZERO;
    endcase

    level_d = (state_d == ONE) || (state_d == WAIT0);
    tick_d  = (state_q == WAIT1) && (state_d == ONE);
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer at 1 MHz / 1 ms (N = 1000). Reference model:
// the level flips once the synchronized input has disagreed with it for N+1 samples.
package tb_debouncer_cfg_pkg;
  localparam int unsigned SimClkFreq    = 1_000_000;
  localparam int unsigned SimStableTime = 1;
  localparam int          N             = (SimClkFreq / 1000) * SimStableTime;
endpackage

module tb_switch_debouncer;
  import tb_debouncer_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  logic sw_i;
  logic db_level_o;
  logic db_tick_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  switch_debouncer #(
    .ClkFreq   (SimClkFreq),
    .StableTime(SimStableTime)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .sw_i      (sw_i),
    .db_level_o(db_level_o),
    .db_tick_o (db_tick_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: delay the raw input by two samples, then count how long it
  // has disagreed with the current level.
  logic m_s1, m_s2, m_level, m_tick;
  int   m_run;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0; m_tick <= 1'b0; m_run <= 0;
    end else begin
      m_s1   <= sw_i;
      m_s2   <= m_s1;
      m_tick <= 1'b0;
      if (m_s2 == m_level) begin
        m_run <= 0;
      end else if (m_run + 1 == N + 1) begin
        m_level <= m_s2;
        m_tick  <= m_s2;
        m_run   <= 0;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic test_reset();
    rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (db_level_o !== 1'b0 || db_tick_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got level=%b tick=%b want 0 0", cyc, db_level_o, db_tick_o);
      end
      sw_i = 1'($urandom_range(0, 1));
    end
    sw_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (db_level_o !== m_level || db_tick_o !== m_tick) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got %b/%b want %b/%b", cyc, db_level_o, db_tick_o, m_level, m_tick);
      end
    end
  endtask

  task automatic test_clean_press();
    int c0, k;
    sw_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 1010; i++) begin
      @(negedge clk);
      k = cyc - c0;
      total++;
      if (db_level_o !== m_level || db_tick_o !== m_tick) begin
        bad++;
        $display("FAIL press_model k=%0d got %b/%b want %b/%b", k, db_level_o, db_tick_o, m_level, m_tick);
      end
      if (k == 1002) begin
        total++;
        if (db_level_o !== 1'b0) begin
          bad++; $display("FAIL press_early k=%0d got level=%b want 0", k, db_level_o);
        end
      end
      if (k == 1003) begin
        total++;
        if (db_level_o !== 1'b1 || db_tick_o !== 1'b1) begin
          bad++; $display("FAIL press_edge k=%0d got %b/%b want 1/1", k, db_level_o, db_tick_o);
        end
      end
      if (k == 1004) begin
        total++;
        if (db_level_o !== 1'b1 || db_tick_o !== 1'b0) begin
          bad++; $display("FAIL press_after k=%0d got %b/%b want 1/0", k, db_level_o, db_tick_o);
        end
      end
    end
  endtask

  task automatic test_release_glitch();
    for (int i = 0; i < 1400; i++) begin
      sw_i = (i < 200) ? 1'b0 : 1'b1;
      @(negedge clk);
      total++;
      if (db_level_o !== 1'b1 || db_tick_o !== 1'b0) begin
        bad++;
        $display("FAIL rel_glitch i=%0d got %b/%b want 1/0", i, db_level_o, db_tick_o);
      end
    end
  endtask

  task automatic test_release();
    int elapsed, len, c0, k;
    elapsed = 0;
    while (elapsed < 2000) begin
      sw_i = ~sw_i;
      len  = int'($urandom_range(5, 500));
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        elapsed++;
        total++;
        if (db_level_o !== 1'b1 || db_tick_o !== 1'b0) begin
          bad++;
          $display("FAIL rel_bounce n=%0d got %b/%b want 1/0", elapsed, db_level_o, db_tick_o);
        end
      end
    end
    if (sw_i == 1'b0) begin
      sw_i = 1'b1;
      repeat (10) @(negedge clk);
    end
    sw_i = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 1010; i++) begin
      @(negedge clk);
      k = cyc - c0;
      total++;
      if (db_level_o !== m_level || db_tick_o !== 1'b0) begin
        bad++;
        $display("FAIL rel_model k=%0d got %b/%b want %b/0", k, db_level_o, db_tick_o, m_level);
      end
      if (k == 1002 || k == 1003) begin
        total++;
        if (db_level_o !== (k == 1002)) begin
          bad++; $display("FAIL rel_edge k=%0d got level=%b want %b", k, db_level_o, k == 1002);
        end
      end
    end
  endtask

  task automatic test_short_glitch();
    int ticks;
    logic saw_level;
    for (int i = 0; i < 2010; i++) begin
      sw_i = (i < 1000) ? 1'b1 : 1'b0;
      @(negedge clk);
      total++;
      if (db_level_o !== 1'b0 || db_tick_o !== 1'b0) begin
        bad++;
        $display("FAIL glitch_1000 i=%0d got %b/%b want 0/0", i, db_level_o, db_tick_o);
      end
    end
    ticks = 0;
    saw_level = 1'b0;
    for (int i = 0; i < 2101; i++) begin
      sw_i = (i < 1001) ? 1'b1 : 1'b0;
      @(negedge clk);
      total++;
      if (db_level_o !== m_level || db_tick_o !== m_tick) begin
        bad++;
        $display("FAIL glitch_1001 i=%0d got %b/%b want %b/%b", i, db_level_o, db_tick_o, m_level, m_tick);
      end
      if (db_tick_o === 1'b1) ticks++;
      if (db_level_o === 1'b1) saw_level = 1'b1;
    end
    total++;
    if (ticks != 1 || saw_level !== 1'b1 || db_level_o !== 1'b0) begin
      bad++;
      $display("FAIL glitch_1001_sum got ticks=%0d rose=%b level=%b want 1 1 0", ticks, saw_level, db_level_o);
    end
  endtask

  task automatic test_bouncy_press();
    int elapsed, len, c0, k, ticks;
    elapsed = 0;
    while (elapsed < 3000) begin
      sw_i = ~sw_i;
      len  = int'($urandom_range(5, 500));
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        elapsed++;
        total++;
        if (db_level_o !== 1'b0 || db_tick_o !== 1'b0) begin
          bad++;
          $display("FAIL bounce_early n=%0d got %b/%b want 0/0", elapsed, db_level_o, db_tick_o);
        end
      end
    end
    if (sw_i == 1'b1) begin
      sw_i = 1'b0;
      repeat (10) @(negedge clk);
    end
    sw_i = 1'b1;
    c0 = cyc;
    ticks = 0;
    for (int i = 0; i < 1010; i++) begin
      @(negedge clk);
      k = cyc - c0;
      if (db_tick_o === 1'b1) ticks++;
      total++;
      if (db_level_o !== m_level || db_tick_o !== m_tick) begin
        bad++;
        $display("FAIL bounce_model k=%0d got %b/%b want %b/%b", k, db_level_o, db_tick_o, m_level, m_tick);
      end
      if (k == 1003) begin
        total++;
        if (db_level_o !== 1'b1 || db_tick_o !== 1'b1) begin
          bad++; $display("FAIL bounce_edge k=%0d got %b/%b want 1/1", k, db_level_o, db_tick_o);
        end
      end
    end
    total++;
    if (ticks != 1) begin
      bad++; $display("FAIL bounce_ticks got %0d want 1", ticks);
    end
  endtask

  task automatic test_async_reset();
    int c0, k;
    // Mid-ONE: the level is high and sw_i still held high.
    total++;
    if (db_level_o !== 1'b1) begin
      bad++; $display("FAIL arst_pre got level=%b want 1", db_level_o);
    end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if (db_level_o !== 1'b0 || db_tick_o !== 1'b0) begin
      bad++; $display("FAIL arst_one got %b/%b want 0/0", db_level_o, db_tick_o);
    end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst_i = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 1010; i++) begin
        @(negedge clk);
        k = cyc - c0;
        total++;
        if (db_level_o !== m_level || db_tick_o !== m_tick) begin
          bad++;
          $display("FAIL arst_model p=%0d k=%0d got %b/%b want %b/%b", pass, k, db_level_o, db_tick_o, m_level, m_tick);
        end
        if (k == 600 || k == 1003) begin
          total++;
          if (db_level_o !== (k == 1003)) begin
            bad++; $display("FAIL arst_rise p=%0d k=%0d got level=%b want %b", pass, k, db_level_o, k == 1003);
          end
        end
      end
      if (pass == 0) begin
        // Fall back to ZERO, then interrupt a fresh WAIT1 halfway through.
        sw_i = 1'b0;
        repeat (1010) @(negedge clk);
        sw_i = 1'b1;
        repeat (500) @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        total++;
        if (db_level_o !== 1'b0 || db_tick_o !== 1'b0) begin
          bad++; $display("FAIL arst_wait1 got %b/%b want 0/0", db_level_o, db_tick_o);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    sw_i  = 1'b0;
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_release();
    test_short_glitch();
    test_bouncy_press();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
